raster_to_block: RTL

RASTER_TO_BLOCK -- requirements
Module: raster_to_block

---
 rtl/jpeg_pkg.sv | 20 ++
 rtl/raster_to_block_if.sv | 28 ++
 rtl/block_buf_ram.sv | 33 +++
 rtl/raster_to_block.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// +----------------------------------------------------------------+
// | jpeg_pkg : constants and read-FSM encoding for the JPEG front end |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

package jpeg_pkg;

  localparam int BLK_DIM  = 8;
  localparam int BLK_SIZE = 64;
  localparam int SAMPLE_W = 8;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/raster_to_block_if.sv
// +----------------------------------------------------------------+
// | raster_to_block_if : raster sample input / 8x8 block output bus  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

interface raster_to_block_if;

  logic                                  En_In;
  logic signed [jpeg_pkg::SAMPLE_W-1:0]  In_Data;
  logic                                  En_Out;
  logic signed [jpeg_pkg::SAMPLE_W-1:0]  Out_Data;
  logic                                  Block_Start;
  logic                                  Frame_End;

  modport master (
    output En_In, In_Data,
    input  En_Out, Out_Data, Block_Start, Frame_End
  );

  modport slave (
    input  En_In, In_Data,
    output En_Out, Out_Data, Block_Start, Frame_End
  );

endinterface

`default_nettype wire

// File: rtl/block_buf_ram.sv
// +----------------------------------------------------------------+
// | block_buf_ram : simple dual-port RAM, registered read port       |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

module block_buf_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              i_wr_en,
  input  wire logic [ADDR_W-1:0] i_wr_addr,
  input  wire logic [DATA_W-1:0] i_wr_data,
  input  wire logic              i_rd_en,
  input  wire logic [ADDR_W-1:0] i_rd_addr,
  output logic      [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/raster_to_block.sv
// +----------------------------------------------------------------+
// | raster_to_block : raster Y samples to 8x8 block order, ping-pong |
// | Optional overrun flag: define RTB_OVF_DETECT_EN   Rev 1.0        |
// +----------------------------------------------------------------+
`default_nettype none

module raster_to_block
  import jpeg_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  wire logic           Clock,
  input  wire logic           Reset_n,
  raster_to_block_if.slave    bus
`ifdef RTB_OVF_DETECT_EN
  ,
  output logic                Overflow
`endif
);

  localparam int STRIP_PX  = BLK_DIM * IMG_WIDTH;
  localparam int ADDR_W    = $clog2(2 * STRIP_PX);
  localparam int COL_W     = $clog2(IMG_WIDTH);
  localparam int ROW_W     = $clog2(BLK_DIM);
  localparam int K_W       = $clog2(BLK_SIZE);
  localparam int NUM_BLK   = IMG_WIDTH / BLK_DIM;
  localparam int BLK_W     = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam int NUM_STRIP = IMG_HEIGHT / BLK_DIM;
  localparam int STRIP_W   = (NUM_STRIP > 1) ? $clog2(NUM_STRIP) : 1;

  logic [ROW_W-1:0]    r_wr_row;
  logic [COL_W-1:0]    r_wr_col;
  logic                r_wr_bank;
  rd_state_t           r_state;
  logic                r_rd_bank;
  logic [BLK_W-1:0]    r_rd_blk;
  logic [K_W-1:0]      r_rd_k;
  logic [STRIP_W-1:0]  r_rd_strip;
  logic                r_p1_vld, r_p1_bs, r_p1_fe;
  logic                r_en_out, r_bs_out, r_fe_out;
  logic [SAMPLE_W-1:0] r_out_data;

  logic                w_swap, w_rd_last, w_rd_en;
  logic [ADDR_W-1:0]   w_wr_addr, w_rd_addr;
  logic [SAMPLE_W-1:0] w_rd_data;

  assign w_swap    = bus.En_In && (r_wr_row == ROW_W'(BLK_DIM - 1))
                                && (r_wr_col == COL_W'(IMG_WIDTH - 1));
  assign w_rd_en   = (r_state == RD_READ);
  assign w_rd_last = w_rd_en && (r_rd_blk == BLK_W'(NUM_BLK - 1))
                             && (r_rd_k == K_W'(BLK_SIZE - 1));

  assign w_wr_addr = ADDR_W'(r_wr_bank) * ADDR_W'(STRIP_PX)
                   + ADDR_W'(r_wr_row) * ADDR_W'(IMG_WIDTH)
                   + ADDR_W'(r_wr_col);
  // Column within the strip is simply {block, k%8} because blocks are 8 wide.
  assign w_rd_addr = ADDR_W'(r_rd_bank) * ADDR_W'(STRIP_PX)
                   + ADDR_W'(r_rd_k[K_W-1:ROW_W]) * ADDR_W'(IMG_WIDTH)
                   + ADDR_W'({r_rd_blk, r_rd_k[ROW_W-1:0]});

  // Write side: raster position inside the current strip; row wraps 7->0 naturally.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_wr_row  <= '0;
      r_wr_col  <= '0;
      r_wr_bank <= 1'b0;
    end else if (bus.En_In) begin
      if (r_wr_col == COL_W'(IMG_WIDTH - 1)) begin
        r_wr_col <= '0;
        r_wr_row <= r_wr_row + 1'b1;
      end else begin
        r_wr_col <= r_wr_col + 1'b1;
      end
      if (w_swap) r_wr_bank <= ~r_wr_bank;
    end
  end

  // Read FSM; a swap during a non-final read cycle is ignored (overrun).
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state    <= RD_IDLE;
      r_rd_bank  <= 1'b0;
      r_rd_blk   <= '0;
      r_rd_k     <= '0;
      r_rd_strip <= '0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          if (w_swap) begin
            r_state   <= RD_READ;
            r_rd_bank <= r_wr_bank;
            r_rd_blk  <= '0;
            r_rd_k    <= '0;
          end
        end
        RD_READ: begin
          r_rd_k <= r_rd_k + 1'b1;
          if (r_rd_k == K_W'(BLK_SIZE - 1)) begin
            r_rd_blk <= w_rd_last ? '0 : r_rd_blk + 1'b1;
          end
          if (w_rd_last) begin
            r_rd_strip <= (r_rd_strip == STRIP_W'(NUM_STRIP - 1)) ? '0
                                                                  : r_rd_strip + 1'b1;
            if (w_swap) r_rd_bank <= r_wr_bank;
            else        r_state   <= RD_IDLE;
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  block_buf_ram #(
    .DEPTH  (2 * STRIP_PX),
    .DATA_W (SAMPLE_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (Clock),
    .i_wr_en   (bus.En_In),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (bus.In_Data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Flags travel one stage alongside the RAM read, then all outputs register together.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_p1_vld   <= 1'b0;
      r_p1_bs    <= 1'b0;
      r_p1_fe    <= 1'b0;
      r_en_out   <= 1'b0;
      r_bs_out   <= 1'b0;
      r_fe_out   <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_p1_vld   <= w_rd_en;
      r_p1_bs    <= w_rd_en && (r_rd_k == '0);
      r_p1_fe    <= w_rd_last && (r_rd_strip == STRIP_W'(NUM_STRIP - 1));
      r_en_out   <= r_p1_vld;
      r_bs_out   <= r_p1_bs;
      r_fe_out   <= r_p1_fe;
      r_out_data <= r_p1_vld ? w_rd_data : '0;
    end
  end

  assign bus.En_Out      = r_en_out;
  assign bus.Out_Data    = r_out_data;
  assign bus.Block_Start = r_bs_out;
  assign bus.Frame_End   = r_fe_out;

`ifdef RTB_OVF_DETECT_EN
  logic r_overflow;

  always_ff @(posedge Clock) begin
    if (!Reset_n)                         r_overflow <= 1'b0;
    else if (w_swap && w_rd_en && !w_rd_last) r_overflow <= 1'b1;
  end

  assign Overflow = r_overflow;
`endif

endmodule

`default_nettype wire
